// File: rtl/game_period_sequencer.sv
// Match-phase controller for the scoreboard countdown timer: sequences
// preliminary, game periods, intermissions and final; owns timer load/run and the horn.
module game_period_sequencer #(
  parameter int unsigned PRELIM_SECS = 300,
  parameter int unsigned PERIOD_SECS = 1200,
  parameter int unsigned BREAK_SECS  = 600,
  parameter int unsigned NUM_PERIODS = 2,
  parameter int unsigned HORN_CYCLES = 50000000,
  parameter int unsigned TIME_W      = 12
) (
  input  logic              Clk100M,
  input  logic              Rst_n,
  input  logic              prelimSig,
  input  logic              pauseSig,
  input  logic              abortSig,
  input  logic              timerDone,
  output logic              timerLoad,
  output logic [TIME_W-1:0] timerValue,
  output logic              timerRun,
  output logic [2:0]        phase,
  output logic [2:0]        periodNum,
  output logic              gameSig,
  output logic              hornOut
);

  localparam int unsigned HORN_W = $clog2(HORN_CYCLES + 1);

  typedef enum logic [2:0] {
    PH_IDLE   = 3'd0,
    PH_PRELIM = 3'd1,
    PH_PERIOD = 3'd2,
    PH_BREAK  = 3'd3,
    PH_FINAL  = 3'd4
  } phase_t;

  if (64'(PRELIM_SECS) >= (64'd1 << TIME_W) || 64'(PERIOD_SECS) >= (64'd1 << TIME_W) ||
      64'(BREAK_SECS) >= (64'd1 << TIME_W)) begin : g_secs_check
    $error("phase durations do not fit in TIME_W bits");
  end
  if (NUM_PERIODS < 1 || NUM_PERIODS > 7) begin : g_periods_check
    $error("NUM_PERIODS must be in 1..7");
  end

  phase_t              state_q, state_d;
  logic [2:0]          period_q, period_d;
  logic                load_q, load_d;
  logic [TIME_W-1:0]   value_q, value_d;
  logic                paused_q, paused_d;
  logic                run_q, run_d;
  logic                game_q;
  logic                horn_q;
  logic [HORN_W-1:0]   horn_cnt_q, horn_cnt_d;
  logic                fire;

  function automatic logic is_timed(input phase_t s);
    return (s == PH_PRELIM) || (s == PH_PERIOD) || (s == PH_BREAK);
  endfunction

  always_ff @(posedge Clk100M or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= PH_IDLE;
      period_q   <= '0;
      load_q     <= 1'b0;
      value_q    <= '0;
      paused_q   <= 1'b0;
      run_q      <= 1'b0;
      game_q     <= 1'b0;
      horn_q     <= 1'b0;
      horn_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      period_q   <= period_d;
      load_q     <= load_d;
      value_q    <= value_d;
      paused_q   <= paused_d;
      run_q      <= run_d;
      game_q     <= (state_d == PH_PERIOD);
      horn_q     <= (horn_cnt_d != '0);
      horn_cnt_q <= horn_cnt_d;
    end
  end

  // Priority chain abort > done > pause > prelim; run enable is derived from the
  // next state so it is registered alongside phase and the load strobe.
  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    load_d   = 1'b0;
    value_d  = value_q;
    paused_d = paused_q;
    fire     = 1'b0;
    if (abortSig) begin
      state_d  = PH_IDLE;
      period_d = '0;
      paused_d = 1'b0;
    end else if (timerDone && is_timed(state_q)) begin
      paused_d = 1'b0;
      case (state_q)
        PH_PRELIM: begin
          state_d  = PH_PERIOD;
          period_d = 3'd1;
          load_d   = 1'b1;
          value_d  = TIME_W'(PERIOD_SECS);
          fire     = 1'b1;
        end
        PH_PERIOD: begin
          fire = 1'b1;
          if (period_q < 3'(NUM_PERIODS)) begin
            state_d = PH_BREAK;
            load_d  = 1'b1;
            value_d = TIME_W'(BREAK_SECS);
          end else begin
            state_d = PH_FINAL;
          end
        end
        default: begin
          state_d  = PH_PERIOD;
          period_d = period_q + 3'd1;
          load_d   = 1'b1;
          value_d  = TIME_W'(PERIOD_SECS);
        end
      endcase
    end else if (pauseSig && is_timed(state_q) && !load_q) begin
      paused_d = ~paused_q;
    end else if (prelimSig && (state_q == PH_IDLE || state_q == PH_FINAL)) begin
      state_d  = PH_PRELIM;
      period_d = '0;
      load_d   = 1'b1;
      value_d  = TIME_W'(PRELIM_SECS);
      paused_d = 1'b0;
    end

    if (abortSig)                horn_cnt_d = '0;
    else if (fire)               horn_cnt_d = HORN_W'(HORN_CYCLES);
    else if (horn_cnt_q != '0)   horn_cnt_d = horn_cnt_q - 1'b1;
    else                         horn_cnt_d = horn_cnt_q;

    run_d = is_timed(state_d) && !paused_d && !load_d;
  end

  always_comb begin
    phase      = state_q;
    periodNum  = period_q;
    timerLoad  = load_q;
    timerValue = value_q;
    timerRun   = run_q;
    gameSig    = game_q;
    hornOut    = horn_q;
  end

endmodule

// File: tb/tb_game_period_sequencer.sv
// Bench for game_period_sequencer: timer model plus reference model with a
// scoreboard of expected timer loads.
module tb_game_period_sequencer;

  localparam int unsigned TW = 12;

  logic          clk = 1'b0;
  logic          rst_n, prelim, pause, abort_s, done;
  logic          timer_load, timer_run, game, horn;
  logic [TW-1:0] timer_value;
  logic [2:0]    phase, period_num;

  always #5 clk = ~clk;

  game_period_sequencer #(
    .PRELIM_SECS(3), .PERIOD_SECS(5), .BREAK_SECS(2),
    .NUM_PERIODS(2), .HORN_CYCLES(4), .TIME_W(TW)
  ) dut (
    .Clk100M(clk), .Rst_n(rst_n), .prelimSig(prelim), .pauseSig(pause),
    .abortSig(abort_s), .timerDone(done), .timerLoad(timer_load),
    .timerValue(timer_value), .timerRun(timer_run), .phase(phase),
    .periodNum(period_num), .gameSig(game), .hornOut(horn)
  );

  typedef struct { int ph; int per; int val; } load_t;
  load_t exp_q[$];

  int tests = 0, fails = 0;
  int m_ph, m_per, m_paused, m_ld, m_hc;
  int tm_cnt, tm_tick;
  int horn_hi;
  bit log_on;
  int prev_ph;
  int seen_ph[$], seen_per[$], seen_load[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_per = 0; m_paused = 0; m_ld = 0; m_hc = 0;
    tm_cnt = 0; tm_tick = 0; prev_ph = 0;
  endtask

  function automatic bit timed(input int p);
    return p >= 1 && p <= 3;
  endfunction

  task automatic model_step();
    bit fire = 0;
    bit nld = 0;
    int val = 0;
    if (abort_s) begin
      m_ph = 0; m_per = 0; m_paused = 0;
    end else if (done && timed(m_ph)) begin
      m_paused = 0;
      if (m_ph == 1) begin
        m_ph = 2; m_per = 1; nld = 1; val = 5; fire = 1;
      end else if (m_ph == 2) begin
        fire = 1;
        if (m_per < 2) begin m_ph = 3; nld = 1; val = 2; end
        else m_ph = 4;
      end else begin
        m_ph = 2; m_per = m_per + 1; nld = 1; val = 5;
      end
    end else if (pause && timed(m_ph) && m_ld == 0) begin
      m_paused = 1 - m_paused;
    end else if (prelim && (m_ph == 0 || m_ph == 4)) begin
      m_ph = 1; m_per = 0; nld = 1; val = 3; m_paused = 0;
    end
    if (abort_s)      m_hc = 0;
    else if (fire)    m_hc = 4;
    else if (m_hc > 0) m_hc = m_hc - 1;
    m_ld = nld;
    if (nld) exp_q.push_back('{m_ph, m_per, val});
  endtask

  task automatic tick();
    load_t e;
    @(posedge clk);
    model_step();
    #1;
    check("phase", 32'(phase), m_ph);
    check("periodNum", 32'(period_num), m_per);
    check("timerLoad", 32'(timer_load), m_ld);
    check("timerRun", 32'(timer_run), (timed(m_ph) && m_paused == 0 && m_ld == 0) ? 1 : 0);
    check("gameSig", 32'(game), (m_ph == 2) ? 1 : 0);
    check("hornOut", 32'(horn), (m_hc != 0) ? 1 : 0);
    if (timer_load === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_load", 32'(timer_value), 0);
      else begin
        e = exp_q.pop_front();
        check("load_value", 32'(timer_value), e.val);
        check("load_phase", 32'(phase), e.ph);
        check("load_period", 32'(period_num), e.per);
      end
    end
    if (horn === 1'b1) horn_hi++;
    if (log_on) begin
      if (32'(phase) != prev_ph) begin
        seen_ph.push_back(int'(phase));
        seen_per.push_back(int'(period_num));
      end
      if (timer_load === 1'b1) seen_load.push_back(int'(timer_value));
    end
    prev_ph = int'(phase);
    done = 1'b0;
    if (timer_load === 1'b1) begin
      tm_cnt = int'(timer_value); tm_tick = 0;
    end else if (timer_run === 1'b1 && tm_cnt > 0) begin
      tm_tick++;
      if (tm_tick == 10) begin
        tm_tick = 0;
        tm_cnt--;
        if (tm_cnt == 0) done = 1'b1;
      end
    end
    prelim = 1'b0; pause = 1'b0; abort_s = 1'b0;
  endtask

  task automatic run_until(input int target, input int limit);
    int n = 0;
    while (int'(phase) != target && n < limit) begin
      tick();
      n++;
    end
    check("reach_phase", 32'(phase), target);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ph[5]  = '{1, 2, 3, 2, 4};
    int exp_per[5] = '{0, 1, 1, 2, 2};
    int exp_ld[4]  = '{3, 5, 2, 5};
    int n;
    rst_n = 1'b0; prelim = 1'b0; pause = 1'b0; abort_s = 1'b0; done = 1'b0;
    horn_hi = 0; log_on = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_phase", 32'(phase), 0);
    check("rst_load", 32'(timer_load), 0);
    check("rst_run", 32'(timer_run), 0);
    check("rst_horn", 32'(horn), 0);
    rst_n = 1'b1;

    // Start and full match
    log_on = 1'b1;
    prelim = 1'b1;
    tick();
    check("start_load", 32'(timer_load), 1);
    check("start_value", 32'(timer_value), 3);
    check("start_phase", 32'(phase), 1);
    check("start_run", 32'(timer_run), 0);
    tick();
    check("start_run_next", 32'(timer_run), 1);
    run_until(2, 100);
    repeat (10) tick();
    pause = 1'b1;
    tick();
    check("pause_run", 32'(timer_run), 0);
    check("pause_phase", 32'(phase), 2);
    repeat (5) tick();
    pause = 1'b1;
    tick();
    check("resume_run", 32'(timer_run), 1);
    run_until(3, 200);
    n = 0;
    while (!(done && int'(phase) == 3) && n < 100) begin tick(); n++; end
    check("break_done_seen", 32'(done), 1);
    pause = 1'b1;
    tick();
    check("coinc_phase", 32'(phase), 2);
    check("coinc_period", 32'(period_num), 2);
    check("coinc_load", 32'(timer_load), 1);
    check("coinc_value", 32'(timer_value), 5);
    tick();
    check("coinc_run", 32'(timer_run), 1);
    run_until(4, 200);
    repeat (6) tick();
    log_on = 1'b0;
    check("horn_cycles", horn_hi, 12);
    check("n_phases", seen_ph.size(), 5);
    for (int i = 0; i < 5 && i < seen_ph.size(); i++) begin
      check("seq_phase", seen_ph[i], exp_ph[i]);
      check("seq_period", seen_per[i], exp_per[i]);
    end
    check("n_loads", seen_load.size(), 4);
    for (int i = 0; i < 4 && i < seen_load.size(); i++) check("seq_load", seen_load[i], exp_ld[i]);

    // Pause ignored in FINAL
    pause = 1'b1;
    tick();
    check("final_pause_phase", 32'(phase), 4);
    check("final_pause_run", 32'(timer_run), 0);

    // Abort coincident with timerDone while horn sounds in PERIOD
    prelim = 1'b1;
    tick();
    run_until(2, 100);
    tick();
    check("mid_horn", 32'(horn), 1);
    abort_s = 1'b1; done = 1'b1;
    tick();
    check("abort_phase", 32'(phase), 0);
    check("abort_period", 32'(period_num), 0);
    check("abort_horn", 32'(horn), 0);
    check("abort_load", 32'(timer_load), 0);
    repeat (4) tick();
    check("abort_horn_quiet", 32'(horn), 0);
    prelim = 1'b1;
    tick();
    check("restart_phase", 32'(phase), 1);
    check("restart_value", 32'(timer_value), 3);

    // Asynchronous reset mid-PERIOD
    run_until(2, 100);
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    check("async_phase", 32'(phase), 0);
    check("async_period", 32'(period_num), 0);
    check("async_load", 32'(timer_load), 0);
    check("async_value", 32'(timer_value), 0);
    check("async_run", 32'(timer_run), 0);
    check("async_game", 32'(game), 0);
    check("async_horn", 32'(horn), 0);
    model_reset();
    done = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    check("held_phase", 32'(phase), 0);
    rst_n = 1'b1;
    repeat (3) tick();

    check("sb_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_period_sequencer.md
Name: game_period_sequencer

Overview:
- Controller for the scoreboard countdown timer: sequences preliminary period -> game periods -> intermissions -> final.
- Loads the timer with the duration of each phase, gates its run enable (pause/resume), and drives the phase/period indicators, gameSig and the horn.
- Sits between the front-panel control pulses and the shared countdown timer; it owns every load and run decision for that timer.

Parameters:
- PRELIM_SECS, 300, preliminary period length in seconds
- PERIOD_SECS, 1200, game period length in seconds
- BREAK_SECS, 600, intermission length in seconds
- NUM_PERIODS, 2, game periods per match (1..7)
- HORN_CYCLES, 50000000, horn pulse length in Clk100M cycles
- TIME_W, 12, width of timerValue

Ports:
- Clk100M  in  1  system clock, all logic on its rising edge
- Rst_n  in  1  asynchronous active-low reset
- prelimSig  in  1  one-cycle start request
- pauseSig  in  1  one-cycle pause/resume toggle
- abortSig  in  1  one-cycle abort to idle
- timerDone  in  1  one-cycle pulse from the countdown timer on reaching 0
- timerLoad  out  1  one-cycle load strobe to the timer
- timerValue  out  TIME_W  seconds to load; valid while timerLoad=1
- timerRun  out  1  timer count enable
- phase  out  3  0=IDLE 1=PRELIM 2=PERIOD 3=BREAK 4=FINAL
- periodNum  out  3  current/last period number, 0 before the first period
- gameSig  out  1  high while phase=PERIOD
- hornOut  out  1  horn drive

Behaviour:
- Interface: one clock (Clk100M). Reset Rst_n is asynchronous, active-low.
- All outputs are registered. An input sampled at edge k is reflected in the outputs after edge k.
- Reset values:
  - phase=IDLE, periodNum=0
  - timerLoad=0, timerValue=0, timerRun=0
  - gameSig=0, hornOut=0
  - internal paused=0, horn counter=0
- Entering any timed phase (PRELIM, PERIOD, BREAK):
  - Same edge: timerLoad=1 and timerValue=that phase's SECS; paused cleared.
  - timerRun=0 in the load cycle; timerRun=1 from the next cycle.
- Transitions:
  - IDLE + prelimSig -> PRELIM.
  - PRELIM + timerDone -> PERIOD; periodNum=1; horn fires.
  - PERIOD + timerDone, periodNum<NUM_PERIODS -> BREAK; horn fires.
  - PERIOD + timerDone, periodNum=NUM_PERIODS -> FINAL; timerRun=0; horn fires.
  - BREAK + timerDone -> PERIOD; periodNum+1.
  - FINAL + prelimSig -> PRELIM; periodNum=0.
- timerRun = (phase in PRELIM/PERIOD/BREAK) AND NOT paused AND NOT load cycle.
- Pause:
  - pauseSig toggles paused only in PRELIM/PERIOD/BREAK.
  - pauseSig is ignored in IDLE and FINAL, and in the load cycle.
- Priority, highest first: abortSig > timerDone > pauseSig > prelimSig.
- abortSig, from any state:
  - -> IDLE; periodNum=0; timerRun=0; paused=0; hornOut=0; horn counter cleared.
  - No timerLoad is issued.
- timerDone while paused is still honoured (the timer had already expired). The transition clears paused.
- timerDone and pauseSig in the same cycle: the transition wins and the pause is discarded.
- timerDone in IDLE or FINAL is ignored. prelimSig in PRELIM/PERIOD/BREAK is ignored.
- Horn:
  - On firing, hornOut=1 for exactly HORN_CYCLES cycles.
  - A refire while sounding restarts the count; no gap.
- Horn counter width: clog2(HORN_CYCLES+1).
- SECS values must fit in TIME_W (elaboration-time check); no truncation at runtime.
- gameSig = (phase==PERIOD), registered together with phase.

Test Plan (PRELIM_SECS=3, PERIOD_SECS=5, BREAK_SECS=2, NUM_PERIODS=2, HORN_CYCLES=4; bench timer model decrements once per 10-cycle tick and pulses timerDone at 0):
- Reset mid-PERIOD, Rst_n low asynchronously -> all outputs at reset values immediately, before the next edge; phase=0.
- prelimSig in IDLE -> next cycle timerLoad=1, timerValue=3, phase=1, timerRun=0; following cycle timerRun=1.
- Full match -> phases 1,2,3,2,4; periodNum 0,1,1,2,2; loads 3,5,2,5; hornOut high 4 cycles at each PRELIM and PERIOD end; gameSig high only in phase 2.
- pauseSig in PERIOD -> timerRun=0 next cycle, phase unchanged; second pauseSig -> timerRun=1. pauseSig in FINAL -> no change.
- timerDone and pauseSig in the same cycle, in BREAK -> PERIOD entered with periodNum=2, load of 5, timerRun=1 after the load cycle.
- abortSig coincident with timerDone, mid-horn in PERIOD -> phase=0, periodNum=0, hornOut=0, no timerLoad. A later prelimSig restarts at PRELIM with load 3.
